// File: rtl/pad_report_arbiter_pkg.sv
// Shared definitions for the pad report arbiter: FSM encoding and frame layout.
// Bit positions index the serializer vector, which shifts out MSB first.
package pad_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2,
      LAST  = 2'd3
   } arb_state_e;

   localparam int FRAME_LEN = 15;

   localparam int START     = 14;
   localparam int OWNER     = 13;
   localparam int COORD_MSB = 12;
   localparam int OP_MSB    = 4;
   localparam int PARITY    = 0;

   localparam logic [3:0] LAST_BIT = 4'(FRAME_LEN - 1);

endpackage

// File: rtl/pad_report_arbiter_if.sv
// Requester/serial-line bundle between two pad reporters and the arbiter.
interface pad_report_arbiter_if;

   logic       enable;
   logic [1:0] req_valid;
   logic [7:0] req_coord0;
   logic [7:0] req_coord1;
   logic [3:0] req_op0;
   logic [3:0] req_op1;
   logic [1:0] req_ready;
   logic       tx_data;
   logic       tx_frame;
   logic       tx_owner;
   logic       busy;

   modport master (
      output enable, req_valid, req_coord0, req_coord1, req_op0, req_op1,
      input  req_ready, tx_data, tx_frame, tx_owner, busy
   );

   modport slave (
      input  enable, req_valid, req_coord0, req_coord1, req_op0, req_op1,
      output req_ready, tx_data, tx_frame, tx_owner, busy
   );

endinterface

// File: rtl/pad_report_arbiter_shifter.sv
// Frame serializer: builds start/owner/coord/op/parity on load and shifts it
// out MSB first, zero-filling so the line idles low once the frame is gone.
module pad_frame_shifter
   import pad_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load_i,
   input  logic       shift_i,
   input  logic       owner_i,
   input  logic [7:0] coord_i,
   input  logic [3:0] op_i,
   output logic       tx_data_o,
   output logic       last_bit_o
);

   logic [FRAME_LEN-1:0] frame;
   logic [FRAME_LEN-1:0] sr_q, sr_d;
   logic [3:0]           cnt_q, cnt_d;

   always_comb begin
      frame                  = '0;
      frame[START]           = 1'b1;
      frame[OWNER]           = owner_i;
      frame[COORD_MSB -: 8]  = coord_i;
      frame[OP_MSB -: 4]     = op_i;
      frame[PARITY]          = ^{owner_i, coord_i, op_i};
   end

   // Load wins over shift so a back-to-back grant replaces the drained frame.
   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (load_i) begin
         sr_d  = frame;
         cnt_d = '0;
      end else if (shift_i) begin
         sr_d = {sr_q[FRAME_LEN-2:0], 1'b0};
         if (cnt_q != LAST_BIT) cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

   assign tx_data_o  = sr_q[FRAME_LEN-1];
   assign last_bit_o = (cnt_q == LAST_BIT);

endmodule

// File: rtl/pad_report_arbiter.sv
// Two-player round-robin arbiter sharing one serial report line, with a
// programmable number of forced idle cycles between frames.
module pad_report_arbiter
   import pad_arb_pkg::*;
#(
   parameter int IDLE_GAP = 2
) (
   input logic                 clk,
   input logic                 reset,
   pad_report_arbiter_if.slave bus
);

   localparam logic [3:0] GAP_END = (IDLE_GAP == 0) ? 4'd0 : 4'(IDLE_GAP - 1);

   arb_state_e state_q;
   logic [3:0] gap_q;
   logic       last_q;
   logic       owner_q;
   logic       frame_q;
   logic [1:0] ready_q;

   logic       win;
   logic       grant_pt;
   logic       grant;
   logic       last_bit;
   logic       tx_data;
   logic [7:0] coord_sel;
   logic [3:0] op_sel;

   always_comb begin
      win = (&bus.req_valid) ? ~last_q : bus.req_valid[1];
      case (state_q)
         SHIFT:   grant_pt = last_bit && (IDLE_GAP == 0);
         GAP:     grant_pt = (gap_q == GAP_END);
         default: grant_pt = 1'b1;
      endcase
      grant     = grant_pt && bus.enable && (|bus.req_valid);
      coord_sel = win ? bus.req_coord1 : bus.req_coord0;
      op_sel    = win ? bus.req_op1    : bus.req_op0;
   end

   // last_q resets to 1 so requester 0 wins the first contention.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         gap_q   <= '0;
         last_q  <= 1'b1;
         owner_q <= 1'b0;
         frame_q <= 1'b0;
         ready_q <= '0;
      end else begin
         ready_q <= '0;
         if (grant) begin
            last_q  <= win;
            owner_q <= win;
            ready_q <= win ? 2'b10 : 2'b01;
            frame_q <= 1'b1;
            gap_q   <= '0;
            state_q <= SHIFT;
         end else begin
            case (state_q)
               SHIFT: begin
                  if (last_bit) begin
                     frame_q <= 1'b0;
                     gap_q   <= '0;
                     state_q <= (IDLE_GAP == 0) ? IDLE : GAP;
                  end
               end
               GAP: begin
                  if (gap_q == GAP_END) state_q <= IDLE;
                  else                  gap_q   <= gap_q + 4'd1;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   pad_frame_shifter u_shifter (
      .clk        (clk),
      .rst        (reset),
      .load_i     (grant),
      .shift_i    (state_q == SHIFT),
      .owner_i    (win),
      .coord_i    (coord_sel),
      .op_i       (op_sel),
      .tx_data_o  (tx_data),
      .last_bit_o (last_bit)
   );

   assign bus.req_ready = ready_q;
   assign bus.tx_data   = tx_data;
   assign bus.tx_frame  = frame_q;
   assign bus.tx_owner  = owner_q;
   assign bus.busy      = (state_q == SHIFT) || (state_q == GAP);

endmodule

// File: tb/tb_pad_report_arbiter.sv
// Scoreboard bench: two arbiters (IDLE_GAP=2 and IDLE_GAP=0); expected frame
// bits are queued as stimulus is driven and popped as the line shifts them out.
module tb_pad_report_arbiter;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   pad_report_arbiter_if ia();
   pad_report_arbiter_if ib();

   pad_report_arbiter #(.IDLE_GAP(2)) dut_a (.clk(clk), .reset(reset), .bus(ia.slave));
   pad_report_arbiter #(.IDLE_GAP(0)) dut_b (.clk(clk), .reset(reset), .bus(ib.slave));

   int checks = 0;
   int errors = 0;

   bit qa[$];
   bit qb[$];
   int gaps_a[$];
   int gaps_b[$];
   int ord[$];

   int pos_a = 0, low_a = 0;
   int pos_b = 0, low_b = 0;

   function automatic logic [14:0] exp_frame(logic o, logic [7:0] c, logic [3:0] p);
      return {1'b1, o, c, p, ^{o, c, p}};
   endfunction

   task automatic push(input bit sel, input logic [14:0] f);
      for (int i = 14; i >= 0; i--) begin
         if (sel) qb.push_back(f[i]);
         else     qa.push_back(f[i]);
      end
   endtask

   // Line monitors: every frame bit is popped from the scoreboard.
   always @(negedge clk) begin
      bit e;
      if (reset) begin
         pos_a = 0; low_a = 0;
      end else if (ia.tx_frame) begin
         if (pos_a == 0) begin gaps_a.push_back(low_a); low_a = 0; end
         checks++;
         if (qa.size() == 0) begin
            errors++;
            $display("FAIL a_unexpected_bit pos=%0d got=%b required=no frame", pos_a, ia.tx_data);
         end else begin
            e = qa.pop_front();
            if (ia.tx_data !== e) begin
               errors++;
               $display("FAIL a_frame_bit pos=%0d got=%b required=%b", pos_a, ia.tx_data, e);
            end
         end
         pos_a = (pos_a == 14) ? 0 : pos_a + 1;
      end else begin
         low_a++; pos_a = 0;
         checks++;
         if (ia.tx_data !== 1'b0) begin
            errors++;
            $display("FAIL a_idle_data got=%b required=0", ia.tx_data);
         end
      end
   end

   always @(negedge clk) begin
      bit e;
      if (reset) begin
         pos_b = 0; low_b = 0;
      end else if (ib.tx_frame) begin
         if (pos_b == 0) begin gaps_b.push_back(low_b); low_b = 0; end
         checks++;
         if (qb.size() == 0) begin
            errors++;
            $display("FAIL b_unexpected_bit pos=%0d got=%b required=no frame", pos_b, ib.tx_data);
         end else begin
            e = qb.pop_front();
            if (ib.tx_data !== e) begin
               errors++;
               $display("FAIL b_frame_bit pos=%0d got=%b required=%b", pos_b, ib.tx_data, e);
            end
         end
         pos_b = (pos_b == 14) ? 0 : pos_b + 1;
      end else begin
         low_b++; pos_b = 0;
         checks++;
         if (ib.tx_data !== 1'b0) begin
            errors++;
            $display("FAIL b_idle_data got=%b required=0", ib.tx_data);
         end
      end
   end

   task automatic drain(input bit sel, input int budget);
      int n;
      n = 0;
      while (((sel ? qb.size() : qa.size()) != 0) && n < budget) begin
         @(negedge clk); n++;
      end
      #1;
      checks++;
      if ((sel ? qb.size() : qa.size()) != 0) begin
         errors++;
         $display("FAIL drain_timeout sel=%0d left=%0d required=0", sel, sel ? qb.size() : qa.size());
      end
   endtask

   // Requester model: drops a non-sticky bit after its ready pulse,
   // optionally raises extra requests after the first grant.
   task automatic serve(input bit sel, input int grants, input logic [1:0] sticky,
                        input logic [1:0] add);
      int cyc;
      logic [1:0] r, v;
      cyc = 0;
      ord.delete();
      while (ord.size() < grants && cyc < 400) begin
         @(negedge clk); cyc++;
         r = sel ? ib.req_ready : ia.req_ready;
         if      (r == 2'b01) ord.push_back(0);
         else if (r == 2'b10) ord.push_back(1);
         else if (r == 2'b11) ord.push_back(9);
         @(posedge clk); #1;
         v = sel ? ib.req_valid : ia.req_valid;
         if (r[0] && !sticky[0]) v[0] = 1'b0;
         if (r[1] && !sticky[1]) v[1] = 1'b0;
         if (r != 2'b00 && ord.size() == 1) v = v | add;
         if (ord.size() >= grants) v = 2'b00;
         if (sel) ib.req_valid = v;
         else     ia.req_valid = v;
      end
      checks++;
      if (ord.size() != grants) begin
         errors++;
         $display("FAIL serve_grants got=%0d required=%0d", ord.size(), grants);
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      #1 reset = 1'b1;
      #1;
      checks++;
      if ({ia.req_ready, ia.tx_data, ia.tx_frame, ia.tx_owner, ia.busy} !== 6'b0) begin
         errors++;
         $display("FAIL reset_outputs_a got=%b required=000000",
                  {ia.req_ready, ia.tx_data, ia.tx_frame, ia.tx_owner, ia.busy});
      end
      checks++;
      if ({ib.req_ready, ib.tx_data, ib.tx_frame, ib.tx_owner, ib.busy} !== 6'b0) begin
         errors++;
         $display("FAIL reset_outputs_b got=%b required=000000",
                  {ib.req_ready, ib.tx_data, ib.tx_frame, ib.tx_owner, ib.busy});
      end
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (5) begin
         @(negedge clk);
         checks++;
         if (ia.tx_frame !== 1'b0 || ia.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle frame=%b busy=%b required=0 0", ia.tx_frame, ia.busy);
         end
      end
   endtask

   task automatic test_single;
      @(posedge clk); #1;
      ia.req_coord0 = 8'hA8; ia.req_op0 = 4'b1001; ia.req_valid = 2'b01;
      push(1'b0, 15'b101010100010011);
      @(posedge clk); #1;
      ia.req_valid = 2'b00; ia.req_coord0 = 8'h5F; ia.req_op0 = 4'h6;
      @(negedge clk);
      checks++;
      if (ia.req_ready !== 2'b01 || ia.tx_frame !== 1'b1 || ia.busy !== 1'b1 || ia.tx_owner !== 1'b0) begin
         errors++;
         $display("FAIL single_grant ready=%b frame=%b busy=%b owner=%b required=01 1 1 0",
                  ia.req_ready, ia.tx_frame, ia.busy, ia.tx_owner);
      end
      @(negedge clk);
      checks++;
      if (ia.req_ready !== 2'b00) begin
         errors++;
         $display("FAIL single_ready_pulse got=%b required=00", ia.req_ready);
      end
      drain(1'b0, 40);
      repeat (4) @(negedge clk);
      checks++;
      if (ia.busy !== 1'b0) begin
         errors++;
         $display("FAIL single_busy_after got=%b required=0", ia.busy);
      end
   endtask

   task automatic test_reset_mid;
      @(posedge clk); #1;
      ia.req_coord0 = 8'h3C; ia.req_op0 = 4'hA; ia.req_valid = 2'b01;
      push(1'b0, exp_frame(1'b0, 8'h3C, 4'hA));
      @(posedge clk); #1;
      ia.req_valid = 2'b00;
      repeat (5) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({ia.req_ready, ia.tx_data, ia.tx_frame, ia.tx_owner, ia.busy} !== 6'b0) begin
         errors++;
         $display("FAIL reset_mid_outputs got=%b required=000000",
                  {ia.req_ready, ia.tx_data, ia.tx_frame, ia.tx_owner, ia.busy});
      end
      qa.delete();
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      repeat (4) begin
         @(negedge clk);
         checks++;
         if (ia.tx_frame !== 1'b0 || ia.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle frame=%b busy=%b required=0 0", ia.tx_frame, ia.busy);
         end
      end
   endtask

   task automatic test_contention;
      gaps_a.delete();
      @(posedge clk); #1;
      ia.req_coord0 = 8'h12; ia.req_op0 = 4'h3;
      ia.req_coord1 = 8'hE7; ia.req_op1 = 4'hC;
      ia.req_valid = 2'b11;
      push(1'b0, exp_frame(1'b0, 8'h12, 4'h3));
      push(1'b0, exp_frame(1'b1, 8'hE7, 4'hC));
      serve(1'b0, 2, 2'b00, 2'b00);
      drain(1'b0, 40);
      checks++;
      if (ord[0] != 0 || ord[1] != 1) begin
         errors++;
         $display("FAIL contention_order got=%0d,%0d required=0,1", ord[0], ord[1]);
      end
      checks++;
      if (gaps_a.size() != 2 || gaps_a[1] != 2) begin
         errors++;
         $display("FAIL contention_gap frames=%0d gap=%0d required=2 2", gaps_a.size(), gaps_a[1]);
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_fairness;
      gaps_a.delete();
      @(posedge clk); #1;
      ia.req_coord0 = 8'h81; ia.req_op0 = 4'h7;
      ia.req_coord1 = 8'h4B; ia.req_op1 = 4'h2;
      ia.req_valid = 2'b01;
      for (int k = 0; k < 4; k++)
         push(1'b0, (k % 2 == 0) ? exp_frame(1'b0, 8'h81, 4'h7) : exp_frame(1'b1, 8'h4B, 4'h2));
      serve(1'b0, 4, 2'b11, 2'b10);
      drain(1'b0, 40);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (ord[k] != k % 2) begin
            errors++;
            $display("FAIL fairness_owner idx=%0d got=%0d required=%0d", k, ord[k], k % 2);
         end
      end
      for (int k = 1; k < 4; k++) begin
         checks++;
         if (gaps_a[k] != 2) begin
            errors++;
            $display("FAIL fairness_gap idx=%0d got=%0d required=2", k, gaps_a[k]);
         end
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_enable;
      @(posedge clk); #1;
      ia.enable = 1'b0;
      ia.req_coord1 = 8'h9D; ia.req_op1 = 4'h5; ia.req_valid = 2'b10;
      repeat (10) begin
         @(negedge clk);
         checks++;
         if (ia.req_ready !== 2'b00 || ia.tx_frame !== 1'b0) begin
            errors++;
            $display("FAIL enable_gated ready=%b frame=%b required=00 0", ia.req_ready, ia.tx_frame);
         end
      end
      @(posedge clk); #1;
      push(1'b0, exp_frame(1'b1, 8'h9D, 4'h5));
      ia.enable = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (ia.tx_frame !== 1'b1 || ia.req_ready !== 2'b10) begin
         errors++;
         $display("FAIL enable_start frame=%b ready=%b required=1 10", ia.tx_frame, ia.req_ready);
      end
      @(posedge clk); #1;
      ia.req_valid = 2'b00;
      repeat (4) @(posedge clk);
      #1 ia.enable = 1'b0;
      drain(1'b0, 30);
      repeat (3) @(negedge clk);
      checks++;
      if (ia.busy !== 1'b0) begin
         errors++;
         $display("FAIL enable_busy_after got=%b required=0", ia.busy);
      end
      ia.enable = 1'b1;
   endtask

   task automatic test_back_to_back;
      gaps_b.delete();
      @(posedge clk); #1;
      ib.req_coord0 = 8'hC3; ib.req_op0 = 4'hE;
      ib.req_coord1 = 8'h06; ib.req_op1 = 4'h1;
      ib.req_valid = 2'b11;
      for (int k = 0; k < 4; k++)
         push(1'b1, (k % 2 == 0) ? exp_frame(1'b0, 8'hC3, 4'hE) : exp_frame(1'b1, 8'h06, 4'h1));
      serve(1'b1, 4, 2'b11, 2'b00);
      drain(1'b1, 40);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (ord[k] != k % 2) begin
            errors++;
            $display("FAIL b2b_owner idx=%0d got=%0d required=%0d", k, ord[k], k % 2);
         end
      end
      for (int k = 1; k < 4; k++) begin
         checks++;
         if (gaps_b[k] != 0) begin
            errors++;
            $display("FAIL b2b_gap idx=%0d got=%0d required=0", k, gaps_b[k]);
         end
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      ia.enable = 1'b1; ia.req_valid = 2'b00;
      ia.req_coord0 = '0; ia.req_coord1 = '0; ia.req_op0 = '0; ia.req_op1 = '0;
      ib.enable = 1'b1; ib.req_valid = 2'b00;
      ib.req_coord0 = '0; ib.req_coord1 = '0; ib.req_op0 = '0; ib.req_op1 = '0;
      test_reset();
      test_single();
      test_reset_mid();
      test_contention();
      test_fairness();
      test_enable();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired required=finish");
      $fatal(1);
   end

endmodule

// File: doc/pad_report_arbiter.md
PAD_REPORT_ARBITER -- requirements
Module: pad_report_arbiter

Interface
REQ-001 Parameter IDLE_GAP, default 2: forced tx_frame-low cycles between consecutive frames; legal range 0..15.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 enable  in  1  high = new grants permitted; low = no new grant, and any frame in flight completes.
REQ-005 req_valid  in  2  per-requester report pending; bit0 = player 0, bit1 = player 1.
REQ-006 req_coord0 / req_coord1  in  8 each  report coordinate, X in [7:4] and Y in [3:0].
REQ-007 req_op0 / req_op1  in  4 each  operation code.
REQ-008 req_ready  out  2  one-cycle accept pulse to the granted requester.
REQ-009 tx_data  out  1  shared serial line.
REQ-010 tx_frame  out  1  high for every frame bit.
REQ-011 tx_owner  out  1  index of the current or last granted requester.
REQ-012 busy  out  1  high while the state is not IDLE.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, SHIFT, GAP, LAST; LAST is unused and decodes to IDLE.
REQ-014 A grant SHALL be evaluated on these clock edges, and only while enable=1:
- any edge in IDLE;
- the edge ending the final GAP cycle;
- the edge ending bit 14 when IDLE_GAP=0.
REQ-015 Round-robin: when both requesters are valid, the one not last granted SHALL win; otherwise the sole valid requester wins.
REQ-016 On grant, the arbiter SHALL do all of the following:
- latch the winner's coord and op;
- set tx_owner;
- pulse req_ready[winner] high for exactly the next cycle;
- enter SHIFT with the bit counter at 0.
REQ-017 Latency: the first frame bit SHALL appear in the cycle immediately after the edge at which req_valid was sampled high.
REQ-018 A frame SHALL be 15 bits on consecutive cycles with tx_frame=1:
- bit 0: start = 1;
- bit 1: owner;
- bits 2-9: coord, MSB first;
- bits 10-13: op, MSB first;
- bit 14: parity = XOR of owner, coord and op.
REQ-019 Latched data SHALL be immune to input changes after the grant.
REQ-020 After bit 14, tx_frame and tx_data SHALL be 0 for exactly IDLE_GAP cycles (GAP state), then IDLE or a new grant per REQ-014.
REQ-021 Outside frames, tx_data SHALL be 0.
REQ-022 A requester dropping req_valid before its grant SHALL be treated as withdrawn, and no frame is sent.
REQ-023 The requester is responsible for holding valid and data stable until req_ready.
REQ-024 enable falling mid-frame SHALL NOT truncate the frame or the gap.
REQ-025 The GAP counter and the 4-bit bit counter SHALL never wrap; each saturates at its terminal count and the state exits.

Reset
REQ-026 While reset=1, the following SHALL be forced immediately, regardless of clk:
- state = IDLE;
- req_ready = 0, tx_data = 0, tx_frame = 0, tx_owner = 0, busy = 0;
- counters = 0;
- the last-grant pointer = 1, so requester 0 wins the first contention.
REQ-027 Reset mid-frame SHALL abandon the frame with no further bits, and the first post-reset frame starts with a fresh start bit.

Structure
REQ-028 Shared package pad_arb_pkg SHALL hold:
- the state encoding;
- FRAME_LEN = 15;
- bit-position constants START, OWNER, COORD_MSB, OP_MSB, PARITY.
REQ-029 The serializer and parity logic SHALL be one sub-module, pad_frame_shifter (load, shift, tx_data, last_bit); arbitration and gap timing stay in the top level.

Verification
REQ-030 Reset check: assert reset mid-run -> all outputs 0 in the same cycle; after release with req_valid=0 -> tx_frame stays 0 and busy=0.
REQ-031 Single request: req0 with coord=8'hA8 and op=4'b1001 -> the cycle after sampling, req_ready=2'b01 for 1 cycle, and tx_data = 1,0,1,0,1,0,1,0,0,0,1,0,0,1,1 with tx_frame high 15 cycles.
REQ-032 Contention after reset: both valid in the same cycle with IDLE_GAP=2 -> requester 0 frame first, then exactly 2 low cycles, then requester 1 frame with owner bit 1.
REQ-033 Fairness: req0 held continuously and req1 asserted during the first frame -> owner sequence 0,1,0,1.
REQ-034 Enable gating: req1 valid while enable=0 for 10 cycles -> no frame and no req_ready; enable raised -> start bit on the next cycle; enable dropped at bit 5 -> frame completes all 15 bits.
REQ-035 IDLE_GAP=0 back-to-back: both requesters continuously valid -> bit 14 of one frame is immediately followed by the start bit of the next.
